// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/PC unit.
// Optional feature macro used by this slice: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'd0,
        PC_PLUS_IMM = 2'd1,
        PC_JALR     = 2'd2,
        PC_RSVD     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // A word fetch target is legal only when its two low bits are clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: PC+4, PC+imm or JALR target, plus link value.
// With FETCH_MISALIGN_TRAP_EN the raw target is passed on; otherwise it is word-aligned.
module pc_next_calc
    import fetch_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic [31:0] immediate,
    input  logic [31:0] alu_result,
    input  pc_src_t     pc_src,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] target_s;

    assign pc_plus4 = instr_pc + PC_STEP;

    // Target select; the reserved encoding falls back to sequential flow.
    always_comb begin
        target_s = pc_plus4;
        case (pc_src)
            PC_PLUS4:    target_s = pc_plus4;
            PC_PLUS_IMM: target_s = instr_pc + immediate;
            PC_JALR:     target_s = alu_result & 32'hFFFF_FFFE;
            PC_RSVD:     target_s = pc_plus4;
            default:     target_s = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = target_s;
`else
    assign next_pc = target_s & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch towards decode.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [24:0] raw_src,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic [31:0] immediate,
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    output logic        misalign_trap
);

    fetch_state_t state_r;
    fetch_state_t state_nx_s;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  next_pc_s;
    logic         capture_s;
    logic         handoff_s;

    pc_next_calc u_pc_next_calc (
        .instr_pc   (pc_r),
        .immediate  (immediate),
        .alu_result (alu_result),
        .pc_src     (pc_src_t'(pc_src)),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc_s)
    );

    // Next-state logic; a response is only looked at once the request has moved us to WAIT.
    always_comb begin
        state_nx_s = state_r;
        capture_s  = 1'b0;
        handoff_s  = 1'b0;
        case (state_r)
            FETCH: begin
                if (imem_req_ready) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    capture_s  = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    handoff_s = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (is_misaligned(next_pc_s[1:0])) begin
                        state_nx_s = TRAP;
                    end else begin
                        state_nx_s = FETCH;
                    end
`else
                    state_nx_s = FETCH;
`endif
                end else begin
                    state_nx_s = ISSUE;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            TRAP:    state_nx_s = TRAP;
`endif
            default: state_nx_s = FETCH;
        endcase
    end

    // State, PC and instruction registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            instr_r <= NOP_INSTR;
        end else begin
            state_r <= state_nx_s;
            if (handoff_s) begin
                pc_r <= next_pc_s;
            end
            if (capture_s) begin
                instr_r <= imem_rsp_data;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_r;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else if (handoff_s && is_misaligned(next_pc_s[1:0])) begin
            trap_r <= 1'b1;
        end
    end

    assign misalign_trap = trap_r;
`else
    assign misalign_trap = 1'b0;
`endif

    assign imem_req_valid = (state_r == FETCH);
    assign imem_addr      = pc_r;
    assign instr_valid    = (state_r == ISSUE);
    assign instr          = instr_r;
    assign raw_src        = instr_r[31:7];
    assign instr_pc       = pc_r;

endmodule
